mul_result: RTL
===============

Name: mul_result

Overview:
- Downstream neighbour of the pipelined multiplier in the MDU.
- Consumes the double-width product in the Memory stage and selects the architectural result: MUL low half, MULH/MULHSU/MULHU high half, or RV64 MULW sign-extended low word.
- Delivers the result to Writeback through a 2-entry valid/ready buffer, so Writeback backpressure never drops or duplicates a product.

Parameters:
XLEN, 64, datapath width; 32 or 64. The word-op path exists only when XLEN=64.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
ProdM  input  2*XLEN  double-width product from multiplier
Funct3M  input  3  multiply type: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
WM  input  1  word op (MULW); ignored when XLEN=32
MulValidM  input  1  ProdM/Funct3M/WM valid this cycle
MulReadyM  output  1  buffer can accept this cycle
FlushW  input  1  synchronous flush of all buffered results
ResultReadyW  input  1  Writeback consumes head this cycle
MulValidW  output  1  head entry valid
MulResultW  output  XLEN  head result

Behaviour:
- Select, combinational on M inputs:
  - WM=1 (XLEN=64): result = {32{ProdM[31]}, ProdM[31:0]}, for any Funct3M.
  - Funct3M=000: result = ProdM[XLEN-1:0].
  - Funct3M=001/010/011: result = ProdM[2*XLEN-1:XLEN].
  - Funct3M[2]=1 is a protocol violation; treat as 000, no assertion in RTL.
- Handshake:
  - accept = MulValidM & MulReadyM.
  - pop = MulValidW & ResultReadyW.
  - MulReadyM = (state != FULL). It is a function of state only, with no combinational path from ResultReadyW.
  - MulValidW = (state != EMPTY).
  - MulResultW = head register.
- Latency: an entry accepted at edge N is visible on MulValidW/MulResultW after edge N. No same-cycle bypass.
- State machine (head, skid registers):
  - EMPTY: accept -> ONE, head<=sel. Otherwise stay.
  - ONE: accept&pop -> ONE, head<=sel. accept&!pop -> FULL, skid<=sel. pop&!accept -> EMPTY. Neither -> stay.
  - FULL: pop -> ONE, head<=skid. accept cannot occur (MulReadyM=0).
- Ordering: strict FIFO; no entry lost, duplicated or reordered.
- Throughput: 1 result/cycle when ResultReadyW is held at 1.
- FlushW=1: next state EMPTY, overriding any accept or pop that cycle; head and skid cleared to 0.
- Reset asserted (reset=0):
  - Immediately: state EMPTY, head=skid=0, MulValidW=0, MulResultW=0, MulReadyM=1.
  - Inputs are ignored until reset deasserts. Applies mid-operation too, with buffered entries discarded.
- Stable outputs: MulResultW stays stable while MulValidW=1 and ResultReadyW=0.

Decomposition:
- Package mdu_pkg holds:
  - Funct3 constants F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU.
  - Buffer state enum {EMPTY, ONE, FULL} (2-bit).
- Sub-module mul_result_sel: combinational select/sign-extend (ProdM, Funct3M, WM -> XLEN result).
- The top level holds the FSM, the head/skid registers and the handshake.

Test Plan:
1. XLEN=64, ProdM=0x0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, Funct3M=000, WM=0, MulValidM=1, ResultReadyW=1 -> next cycle MulValidW=1, MulResultW=0xFFFF_FFFF_FFFF_FFFE.
2. Same ProdM with Funct3M=001, then 010, then 011 -> MulResultW=0x0000_0000_0000_0001 for each, on consecutive cycles.
3. ProdM low word 0x8000_0000, WM=1, Funct3M=000 -> MulResultW=0xFFFF_FFFF_8000_0000. Low word 0x7FFF_FFFF -> 0x0000_0000_7FFF_FFFF.
4. Backpressure, ResultReadyW=0:
   - Offer A, B, C on consecutive cycles -> A and B accepted, MulReadyM=0 while C is offered.
   - Raise ResultReadyW -> outputs A, B, C in order, each exactly once.
5. Flush, then reset:
   - In FULL, pulse FlushW -> next cycle MulValidW=0, MulReadyM=1.
   - In ONE, drive reset=0 between edges -> MulValidW=0 and MulResultW=0 without waiting for a clock edge.
   - After release, one entry -> appears one cycle later.
6. Streaming with ResultReadyW=1 and MulValidM=1 for 8 cycles, results 1..8 -> state stays ONE, MulReadyM stays 1, results 1..8 appear on consecutive cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// MDU shared definitions: multiply funct3 codes and
// the result-buffer state encoding.
package mdu_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_t;

endpackage

// File: rtl/mul_result_if.sv
// Memory-to-Writeback handshake bundle for the
// multiply result buffer.
interface mul_result_if #(
   parameter int XLEN = 64
);
   logic [2*XLEN-1:0] ProdM;
   logic [2:0]        Funct3M;
   logic              WM;
   logic              MulValidM;
   logic              MulReadyM;
   logic              FlushW;
   logic              ResultReadyW;
   logic              MulValidW;
   logic [XLEN-1:0]   MulResultW;

   modport master (
      output ProdM, Funct3M, WM, MulValidM,
      output FlushW, ResultReadyW,
      input  MulReadyM, MulValidW, MulResultW
   );

   modport slave (
      input  ProdM, Funct3M, WM, MulValidM,
      input  FlushW, ResultReadyW,
      output MulReadyM, MulValidW, MulResultW
   );
endinterface

// File: rtl/mul_result_sel.sv
// Picks the architectural result out of the
// double-width product: low, high or MULW word.
module mul_result_sel
   import mdu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2*XLEN-1:0] prod,
   input  logic [2:0]        funct3,
   input  logic              word,
   output logic [XLEN-1:0]   result
);

   logic            word_op;
   logic            hi_op;
   logic [XLEN-1:0] wext;

   // Word ops only exist on RV64
   assign word_op = word && (XLEN == 64);
   assign hi_op   = !word_op &&
                    (funct3 == F3_MULH ||
                     funct3 == F3_MULHSU ||
                     funct3 == F3_MULHU);
   assign wext    = XLEN'($signed(prod[31:0]));

   always_comb begin
      result = prod[XLEN-1:0];
      unique case (1'b1)
         word_op: result = wext;
         hi_op:   result = prod[2*XLEN-1:XLEN];
         default: result = prod[XLEN-1:0];
      endcase
   end

endmodule

// File: rtl/mul_result.sv
// Multiply result stage: select plus a 2-entry
// head/skid buffer toward Writeback.
module mul_result
   import mdu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input logic         clk,
   input logic         reset,
   mul_result_if.slave bus
);

   buf_state_t      state;
   buf_state_t      state_nxt;
   logic            ready;
   logic            valid;
   logic            accept;
   logic            pop;
   logic            ld_head_sel;
   logic            ld_head_skid;
   logic            ld_skid;
   logic [XLEN-1:0] sel;
   logic [XLEN-1:0] head;
   logic [XLEN-1:0] skid;

   mul_result_sel #(.XLEN(XLEN)) u_sel (
      .prod   (bus.ProdM),
      .funct3 (bus.Funct3M),
      .word   (bus.WM),
      .result (sel)
   );

   // Ready depends on state only, never on ResultReadyW
   assign ready  = (state != FULL);
   assign valid  = (state != EMPTY);
   assign accept = bus.MulValidM & ready;
   assign pop    = valid & bus.ResultReadyW;

   assign bus.MulReadyM  = ready;
   assign bus.MulValidW  = valid;
   assign bus.MulResultW = head;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         EMPTY: if (accept) state_nxt = ONE;
         ONE: begin
            if (accept && !pop)      state_nxt = FULL;
            else if (pop && !accept) state_nxt = EMPTY;
         end
         FULL:    if (pop) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
      if (bus.FlushW) state_nxt = EMPTY;
   end

   always_comb begin
      ld_head_sel  = 1'b0;
      ld_head_skid = 1'b0;
      ld_skid      = 1'b0;
      unique case (state)
         EMPTY: ld_head_sel = accept;
         ONE: begin
            ld_head_sel = accept & pop;
            ld_skid     = accept & !pop;
         end
         FULL:    ld_head_skid = pop;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head <= '0;
         skid <= '0;
      end else if (bus.FlushW) begin
         head <= '0;
         skid <= '0;
      end else begin
         if (ld_head_sel)       head <= sel;
         else if (ld_head_skid) head <= skid;
         if (ld_skid)           skid <= sel;
      end
   end

endmodule
